// File: rtl/riscboy_dispctrl_rx_if.sv
// Receive-side word stream: FIFO head word with its DC tag, valid/ready pop, occupancy.
// The receiver drives the master side; the consumer holds the slave side and drives rx_ready.
interface riscboy_dispctrl_rx_if #(
    parameter int W_LEVEL = 3
);
    logic [15:0]        rx_data;
    logic               rx_dc;
    logic               rx_valid;
    logic               rx_ready;
    logic [W_LEVEL-1:0] rx_level;

    modport master (
        output rx_data,
        output rx_dc,
        output rx_valid,
        output rx_level,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_dc,
        input  rx_valid,
        input  rx_level,
        output rx_ready
    );
endinterface

// File: rtl/riscboy_dispctrl_rx.sv
// Display-link receiver: 2FF-syncs SCK/CSn/DC/DAT, assembles 8/16-bit words, queues {word, dc}.
// Push lands 2 clk_sys after the final SCK rise is first sampled; a full FIFO with no pop drops the word.
module riscboy_dispctrl_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int W_LEVEL    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk_sys,
    input  logic                         rst_sys,
    input  logic                         lcd_sck,
    input  logic                         lcd_csn,
    input  logic                         lcd_dc,
    input  logic [7:0]                   lcd_dat,
    input  logic                         cfg_octal,
    input  logic                         cfg_16bit,
    riscboy_dispctrl_rx_if.master        rx,
    output logic                         busy,
    output logic                         err_overflow,
    output logic                         err_frame,
    input  logic                         err_clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [W_LEVEL-1:0] DEPTH_L = W_LEVEL'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_e;

    logic             sck_s1_q, sck_s2_q, sck_d_q;
    logic             csn_s1_q, csn_s2_q;
    logic             dc_s1_q, dc_s2_q;
    logic [7:0]       dat_s1_q, dat_s2_q;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;      // {octal, 16bit}
    logic [3:0]       beat_q, beat_d;
    logic [15:0]      shreg_q, shreg_d;
    logic             err_overflow_q, err_frame_q;

    logic [16:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [W_LEVEL-1:0] level_q, level_d;

    logic             rise;
    logic [15:0]      shifted;
    logic [15:0]      word;
    logic [3:0]       last_beat;
    logic             push, frame_set;
    logic             pop, full, push_ok;

    assign rise = sck_s2_q && !sck_d_q;

    always_comb begin
        case (mode_q)
            2'b00:   last_beat = 4'd7;
            2'b01:   last_beat = 4'd15;
            2'b10:   last_beat = 4'd0;
            default: last_beat = 4'd1;
        endcase
    end

    assign shifted = mode_q[1] ? {shreg_q[7:0], dat_s2_q} : {shreg_q[14:0], dat_s2_q[0]};
    assign word    = mode_q[0] ? shifted : {8'h00, shifted[7:0]};

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        beat_d    = beat_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!csn_s2_q) begin
                    state_d = ACTIVE;
                    mode_d  = {cfg_octal, cfg_16bit};
                    beat_d  = 4'd0;
                end
            end
            ACTIVE: begin
                // Deselect wins over a coincident SCK rise; any held beats are a broken frame.
                if (csn_s2_q) begin
                    state_d   = IDLE;
                    frame_set = (beat_q != 4'd0);
                    beat_d    = 4'd0;
                end else if (rise) begin
                    shreg_d = shifted;
                    if (beat_q == last_beat) begin
                        push   = 1'b1;
                        beat_d = 4'd0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign pop     = (level_q != '0) && rx.rx_ready;
    assign full    = (level_q == DEPTH_L);
    assign push_ok = push && (!full || pop);

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop)
            level_d = level_q + 1'b1;
        else if (!push_ok && pop)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            sck_s1_q       <= 1'b0;
            sck_s2_q       <= 1'b0;
            sck_d_q        <= 1'b0;
            csn_s1_q       <= 1'b1;
            csn_s2_q       <= 1'b1;
            dc_s1_q        <= 1'b0;
            dc_s2_q        <= 1'b0;
            dat_s1_q       <= 8'h00;
            dat_s2_q       <= 8'h00;
            state_q        <= IDLE;
            mode_q         <= 2'b00;
            beat_q         <= 4'd0;
            shreg_q        <= 16'h0000;
            err_overflow_q <= 1'b0;
            err_frame_q    <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= 17'h0;
        end else begin
            sck_s1_q <= lcd_sck;
            sck_s2_q <= sck_s1_q;
            sck_d_q  <= sck_s2_q;
            csn_s1_q <= lcd_csn;
            csn_s2_q <= csn_s1_q;
            dc_s1_q  <= lcd_dc;
            dc_s2_q  <= dc_s1_q;
            dat_s1_q <= lcd_dat;
            dat_s2_q <= dat_s1_q;
            state_q  <= state_d;
            mode_q   <= mode_d;
            beat_q   <= beat_d;
            shreg_q  <= shreg_d;
            level_q  <= level_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {word, dc_s2_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            // Set beats clear when both land on the same edge.
            if (push && !push_ok)
                err_overflow_q <= 1'b1;
            else if (err_clr)
                err_overflow_q <= 1'b0;
            if (frame_set)
                err_frame_q <= 1'b1;
            else if (err_clr)
                err_frame_q <= 1'b0;
        end
    end

    assign rx.rx_data    = mem_q[rd_ptr_q][16:1];
    assign rx.rx_dc      = mem_q[rd_ptr_q][0];
    assign rx.rx_valid   = (level_q != '0);
    assign rx.rx_level   = level_q;
    assign busy          = !csn_s2_q || (beat_q != 4'd0);
    assign err_overflow  = err_overflow_q;
    assign err_frame     = err_frame_q;
endmodule

// File: tb/tb_riscboy_dispctrl_rx.sv
// Bench for riscboy_dispctrl_rx: directed link traffic, a cycle-timed queue model checked every cycle,
// plus literal expectations from the test plan.
module tb_riscboy_dispctrl_rx;
    localparam int DEPTH = 4;

    logic       clk_sys = 1'b0;
    logic       rst_sys = 1'b1;
    logic       lcd_sck = 1'b0;
    logic       lcd_csn = 1'b1;
    logic       lcd_dc  = 1'b0;
    logic [7:0] lcd_dat = 8'h00;
    logic       cfg_octal = 1'b0;
    logic       cfg_16bit = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy, err_overflow, err_frame;

    riscboy_dispctrl_rx_if #(.W_LEVEL(3)) ifc ();

    riscboy_dispctrl_rx #(.FIFO_DEPTH(DEPTH), .W_LEVEL(3)) dut (
        .clk_sys      (clk_sys),
        .rst_sys      (rst_sys),
        .lcd_sck      (lcd_sck),
        .lcd_csn      (lcd_csn),
        .lcd_dc       (lcd_dc),
        .lcd_dat      (lcd_dat),
        .cfg_octal    (cfg_octal),
        .cfg_16bit    (cfg_16bit),
        .rx           (ifc),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_frame    (err_frame),
        .err_clr      (err_clr)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: expected FIFO contents and flags, advanced at each clk_sys edge from scheduled events.
    typedef struct {
        int          n;
        bit          frame;
        logic [15:0] d;
        bit          dc;
    } ev_t;

    ev_t         sched[$];
    logic [16:0] mq[$];
    bit          m_ovf = 1'b0;
    bit          m_frm = 1'b0;
    int          cyc = 0;

    always @(posedge clk_sys) begin : model
        ev_t ev;
        bit  ovf_set;
        bit  frm_set;
        cyc++;
        if (rst_sys) begin
            mq.delete();
            sched.delete();
            m_ovf = 1'b0;
            m_frm = 1'b0;
        end else begin
            ovf_set = 1'b0;
            frm_set = 1'b0;
            if (mq.size() != 0 && ifc.rx_ready)
                void'(mq.pop_front());
            while (sched.size() != 0 && sched[0].n <= cyc) begin
                ev = sched.pop_front();
                if (ev.frame)
                    frm_set = 1'b1;
                else if (mq.size() < DEPTH)
                    mq.push_back({ev.d, ev.dc});
                else
                    ovf_set = 1'b1;
            end
            if (err_clr) begin
                m_ovf = 1'b0;
                m_frm = 1'b0;
            end
            if (ovf_set) m_ovf = 1'b1;
            if (frm_set) m_frm = 1'b1;
        end
    end

    always @(negedge clk_sys) begin
        if (chk_on && !rst_sys) begin
            chk("rx_valid", ifc.rx_valid, mq.size() != 0);
            chk("rx_level", ifc.rx_level, mq.size());
            if (mq.size() != 0) begin
                chk("rx_data", ifc.rx_data, mq[0][16:1]);
                chk("rx_dc", ifc.rx_dc, mq[0][0]);
            end
            chk("err_overflow", err_overflow, m_ovf);
            chk("err_frame", err_frame, m_frm);
        end
    end

    // One SCK beat at clk_sys/8; a final beat schedules its push 3 edges after the rise is driven.
    task automatic beat(input logic [7:0] d, input bit dc, input bit last,
                        input logic [15:0] w, input bit pop_with);
        ev_t ev;
        lcd_dat = d;
        lcd_dc  = dc;
        repeat (4) @(negedge clk_sys);
        lcd_sck = 1'b1;
        if (last) begin
            ev.n = cyc + 3; ev.frame = 1'b0; ev.d = w; ev.dc = dc;
            sched.push_back(ev);
        end
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk_sys);
            if (pop_with && j == 2) ifc.rx_ready = 1'b1;
            if (pop_with && j == 3) ifc.rx_ready = 1'b0;
        end
        lcd_sck = 1'b0;
    endtask

    task automatic send_word(input bit oct, input bit w16, input logic [15:0] w,
                             input bit dc, input bit pop_last);
        int          nb;
        logic [7:0]  d;
        logic [15:0] expw;
        nb   = oct ? (w16 ? 2 : 1) : (w16 ? 16 : 8);
        expw = w16 ? w : {8'h00, w[7:0]};
        for (int i = nb - 1; i >= 0; i--) begin
            d = oct ? w[8*i +: 8] : {7'h55, w[i]};
            beat(d, dc, i == 0, expw, pop_last && i == 0);
        end
    endtask

    task automatic select(input bit oct, input bit w16);
        cfg_octal = oct;
        cfg_16bit = w16;
        lcd_csn   = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic deselect(input bit partial);
        ev_t ev;
        lcd_csn = 1'b1;
        if (partial) begin
            ev.n = cyc + 3; ev.frame = 1'b1; ev.d = 16'h0; ev.dc = 1'b0;
            sched.push_back(ev);
        end
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic pop_chk(input string nm, input logic [15:0] d, input bit dc);
        chk(nm, ifc.rx_data, d);
        chk({nm, "_dc"}, ifc.rx_dc, dc);
        ifc.rx_ready = 1'b1;
        @(negedge clk_sys);
        ifc.rx_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        @(negedge clk_sys);
        err_clr = 1'b0;
    endtask

    initial begin
        ifc.rx_ready = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_valid", ifc.rx_valid, 0);
        chk("rst_level", ifc.rx_level, 0);
        chk("rst_data", ifc.rx_data, 0);
        chk("rst_dc", ifc.rx_dc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", err_overflow, 0);
        chk("rst_frm", err_frame, 0);
        rst_sys = 1'b0;
        chk_on  = 1'b1;
        @(negedge clk_sys);

        // Serial 16-bit
        select(1'b0, 1'b1);
        chk("sel_busy", busy, 1);
        send_word(1'b0, 1'b1, 16'hA55A, 1'b1, 1'b0);
        deselect(1'b0);
        chk("s16_valid", ifc.rx_valid, 1);
        chk("s16_level", ifc.rx_level, 1);
        chk("s16_frm", err_frame, 0);
        pop_chk("s16_data", 16'hA55A, 1'b1);
        chk("s16_empty", ifc.rx_valid, 0);

        // Octal 8-bit
        select(1'b1, 1'b0);
        send_word(1'b1, 1'b0, 16'h002C, 1'b0, 1'b0);
        send_word(1'b1, 1'b0, 16'h0012, 1'b1, 1'b0);
        send_word(1'b1, 1'b0, 16'h0034, 1'b1, 1'b0);
        deselect(1'b0);
        chk("o8_level", ifc.rx_level, 3);
        pop_chk("o8_w0", 16'h002C, 1'b0);
        pop_chk("o8_w1", 16'h0012, 1'b1);
        pop_chk("o8_w2", 16'h0034, 1'b1);

        // Framing error
        select(1'b1, 1'b1);
        beat(8'hFF, 1'b1, 1'b0, 16'h0, 1'b0);
        deselect(1'b1);
        chk("frm_set", err_frame, 1);
        chk("frm_busy", busy, 0);
        chk("frm_nopush", ifc.rx_valid, 0);
        select(1'b1, 1'b1);
        send_word(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        deselect(1'b0);
        pop_chk("frm_beef", 16'hBEEF, 1'b0);
        clr_pulse();
        chk("frm_clr", err_frame, 0);

        // Overflow, then same-edge pop rescues the fifth push
        select(1'b1, 1'b0);
        for (int v = 1; v <= 5; v++)
            send_word(1'b1, 1'b0, 16'(v), 1'b0, 1'b0);
        chk("ovf_level", ifc.rx_level, 4);
        chk("ovf_flag", err_overflow, 1);
        deselect(1'b0);
        for (int v = 1; v <= 4; v++)
            pop_chk("ovf_pop", 16'(v), 1'b0);
        clr_pulse();
        chk("ovf_clr", err_overflow, 0);
        select(1'b1, 1'b0);
        for (int v = 1; v <= 5; v++)
            send_word(1'b1, 1'b0, 16'(v), 1'b0, v == 5);
        chk("ovf2_flag", err_overflow, 0);
        chk("ovf2_level", ifc.rx_level, 4);
        deselect(1'b0);
        for (int v = 2; v <= 5; v++)
            pop_chk("ovf2_pop", 16'(v), 1'b0);

        // Config latched at select; mid-word change is ignored
        select(1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] pat;
            pat = 8'h81;
            if (i == 4) cfg_octal = 1'b1;
            beat({7'h55, pat[i]}, 1'b1, i == 0, 16'h0081, 1'b0);
        end
        deselect(1'b0);
        pop_chk("cfg_ser", 16'h0081, 1'b1);
        select(1'b1, 1'b0);
        send_word(1'b1, 1'b0, 16'h005A, 1'b0, 1'b0);
        deselect(1'b0);
        pop_chk("cfg_oct", 16'h005A, 1'b0);

        // Reset mid-word with one word queued
        select(1'b0, 1'b0);
        send_word(1'b0, 1'b0, 16'h003C, 1'b0, 1'b0);
        for (int i = 7; i >= 3; i--)
            beat({7'h55, i[0]}, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("rmw_queued", ifc.rx_level, 1);
        rst_sys = 1'b1;
        lcd_csn = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("rmw_valid", ifc.rx_valid, 0);
        chk("rmw_level", ifc.rx_level, 0);
        chk("rmw_data", ifc.rx_data, 0);
        chk("rmw_dc", ifc.rx_dc, 0);
        chk("rmw_busy", busy, 0);
        chk("rmw_ovf", err_overflow, 0);
        chk("rmw_frm", err_frame, 0);
        rst_sys = 1'b0;
        repeat (2) @(negedge clk_sys);
        select(1'b0, 1'b1);
        send_word(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        deselect(1'b0);
        chk("rmw_level2", ifc.rx_level, 1);
        pop_chk("rmw_word", 16'h1234, 1'b0);
        chk("rmw_frm2", err_frame, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscboy_dispctrl_rx.md
# riscboy_dispctrl_rx

Display-link receiver: the far end of the RISCBoy display serial/octal link. Oversamples SCK, CSn, DC and the 8-bit data bus in the `clk_sys` domain and reassembles 8- or 16-bit words. Pushes each word, tagged with its DC level, into a small output FIFO with a valid/ready interface. Used as the capture side of a display-link loopback, and as a receiver for a second RISCBoy acting as a display.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: output FIFO entries; power of 2, ≥2.
- `W_LEVEL`, default `$clog2(FIFO_DEPTH+1)`: width of `rx_level`.

Ports:
- `clk_sys`  in  1  sole clock; all state is on its rising edge.
- `rst_sys`  in  1  synchronous, active-high reset.
- `lcd_sck`  in  1  link clock, asynchronous; data is valid on its rising edge.
- `lcd_csn`  in  1  chip select, asynchronous, active low.
- `lcd_dc`  in  1  data/command tag, asynchronous.
- `lcd_dat`  in  8  data bus, asynchronous; serial mode uses only `lcd_dat[0]`.
- `cfg_octal`  in  1  0 = serial (1 bit per edge), 1 = octal (8 bits per edge).
- `cfg_16bit`  in  1  0 = 8-bit words, 1 = 16-bit words.
- `rx_data`  out  16  FIFO head word; 8-bit words are zero-extended.
- `rx_dc`  out  1  DC tag of the head word.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer pop; a pop occurs when `rx_valid && rx_ready`.
- `rx_level`  out  W_LEVEL  FIFO occupancy.
- `busy`  out  1  synced CSn is low, or a partial word is held.
- `err_overflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `err_frame`  out  1  sticky: CSn deasserted with a partial word held.
- `err_clr`  in  1  clears both sticky flags.

## Operation

- **Synchronisers.** SCK, CSn, DC and DAT each pass through a 2FF synchroniser (`*_s2` outputs). A further register `sck_d` delays `sck_s2`. `rise = sck_s2 && !sck_d`.
- **SCK rate limit.** SCK high and low phases must each be ≥3 `clk_sys` periods. DAT and DC must be stable from 3 cycles before each SCK rise to 3 cycles after it. Faster SCK is unsupported; no detection is required.
- **States:**
  - IDLE: synced CSn is high.
  - ACTIVE: synced CSn is low.
- **IDLE → ACTIVE** on synced CSn falling. On that cycle, latch `cfg_octal` and `cfg_16bit` into `mode_q`, and clear the beat counter. Config changes while ACTIVE have no effect until the next select.
- **Beats per word:**
  - serial, 8-bit: 8
  - serial, 16-bit: 16
  - octal, 8-bit: 1
  - octal, 16-bit: 2
- **Word assembly.** On each `rise` in ACTIVE, shift the 16-bit shift register left by 1 (serial, inserting `dat_s2[0]`) or by 8 (octal, inserting `dat_s2`), then increment the beat counter. Words are MSB first; in octal 16-bit mode the first beat is the high byte.
- **Word completion.** On the beat that completes a word:
  - push `{word, dc_s2}` into the FIFO, where DC is the value sampled on the final beat;
  - clear the beat counter in the same cycle.
- **ACTIVE → IDLE** on synced CSn rising. If the beat counter is non-zero, discard the partial word, clear the counter and set `err_frame`.
- **Simultaneous edges.** A `rise` in the same cycle that synced CSn is high is ignored.
- **FIFO push and pop:**
  - A push is accepted if the FIFO is not full, or a pop occurs in the same cycle.
  - Otherwise the word is dropped and `err_overflow` is set. Stored entries are untouched.
  - Push and pop in the same cycle leave `rx_level` unchanged.
- **Sticky flags.** `err_clr` clears both flags. If `err_clr` and a new error occur in the same cycle, the flag is set (set wins).

## Timing

- **Reset values:**
  - FIFO empty; `rx_valid`=0, `rx_level`=0, `rx_data`=0, `rx_dc`=0.
  - `busy`=0, `err_overflow`=0, `err_frame`=0.
  - Beat counter and shift register 0; `mode_q`=0 (serial, 8-bit).
  - Synchroniser SCK and DC stages 0; CSn stages 1, so reset starts in IDLE.
- **Reset mid-word** discards the partial word and all FIFO contents. The link must see CSn high-to-low again before capture resumes.
- **Latency.** Let edge k be the `clk_sys` edge that first samples the final SCK rise into the first sync stage. Then `rise` is high during cycle k+2, the push occurs at edge k+2, and `rx_valid` is high from edge k+2 (when the FIFO was previously empty). `rx_data` and `rx_dc` are registered FIFO outputs and are valid whenever `rx_valid` is 1.
- **Sticky flag timing.** `err_frame` sets at the edge where synced CSn rise is processed, 2 cycles after CSn is first sampled high. `err_overflow` sets at the dropped-push edge.
- **`busy`** is combinational from synced CSn and the beat counter (registered sources only).
- **Throughput** is 1 word per `clk_sys` cycle at most; the SCK rate limit bounds it far lower.

## Test plan

- **Serial 16-bit:** reset, then CSn low; serial 16-bit; DC=1; shift `0xA55A` MSB first at SCK = `clk_sys`/8; CSn high. Expect `rx_valid`=1, `rx_data`=`0xA55A`, `rx_dc`=1, `rx_level`=1, `err_frame`=0. Pop, then `rx_valid`=0.
- **Octal 8-bit:** send bytes `0x2C` (DC=0), then `0x12`, `0x34` (DC=1). Expect 3 entries in order: `0x002C`/0, `0x0012`/1, `0x0034`/1.
- **Framing error:** octal 16-bit; one beat `0xFF`, then CSn high. Expect no push, `err_frame`=1, `busy`=0. Next select, send `0xBE`,`0xEF`: expect `0xBEEF`. `err_clr` pulse clears `err_frame`.
- **Overflow:** `FIFO_DEPTH`=4 with `rx_ready`=0; send 5 octal 8-bit words 1..5. Expect `rx_level`=4, `err_overflow`=1, and pops return 1,2,3,4. Repeat with `rx_ready` held 1 on the 5th push cycle: no overflow.
- **Config latch:** CSn low in serial 8-bit mode; switch `cfg_octal`=1 mid-word; send 8 serial bits `0x81`. Expect `0x0081`. New mode applies only after the next CSn fall.
- **Reset mid-word:** assert `rst_sys` after 5 serial bits with 1 word queued. Expect all outputs at reset values; subsequent full words are captured correctly.
